data_memory: RTL

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 122 ++++++++++++
 1 files changed

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//   Word-addressed 32-bit data RAM with sub-word stores and a self-clearing
//   array. After reset, or on an accepted clear_req, a CLEAR sequence zeroes
//   one word per cycle. The sequence covers all DEPTH words. Reads are
//   combinational and forced to zero while the clear runs.
//
// Ports
//   clk               in   single clock, all state changes on rising edge
//   rst               in   asynchronous active-low reset
//   datamem_rd_addr0  in   [AW-1:0] read word address
//   datamem_rd_dout0  out  [31:0]   read data (0 while busy)
//   datamem_wr_addr0  in   [AW-1:0] write word address
//   datamem_wr_din0   in   [31:0]   unshifted store data
//   datamem_we0       in   write enable
//   datamem_wr_strb   in   [2:0]    000 word, {0,h,1} half h, {1,b} byte b,
//                                   010 illegal
//   clear_req         in   request to zero the whole array
//   busy              out  high while a clear sequence runs
//   err_strb          out  sticky illegal-strobe flag
// ---------------------------------------------------------------------------
module data_memory #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] datamem_rd_addr0,
  output logic [31:0]   datamem_rd_dout0,
  input  logic [AW-1:0] datamem_wr_addr0,
  input  logic [31:0]   datamem_wr_din0,
  input  logic          datamem_we0,
  input  logic [2:0]    datamem_wr_strb,
  input  logic          clear_req,
  output logic          busy,
  output logic          err_strb
);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic          strb_illegal;
  logic          clear_accept;
  logic          wr_accept;
  logic [31:0]   wdata_d;

  assign strb_illegal = (datamem_wr_strb == 3'b010);
  assign clear_accept = (state_q == READY) && clear_req;
  // A write in the same cycle as an accepted clear is dropped.
  assign wr_accept    = (state_q == READY) && datamem_we0 && !clear_req;

  // Read-modify-write merge: only the selected lane changes.
  always_comb begin
    wdata_d = mem_q[datamem_wr_addr0];
    casez (datamem_wr_strb)
      3'b000: wdata_d = datamem_wr_din0;
      3'b0?1: begin
        if (datamem_wr_strb[1]) begin
          wdata_d[31:16] = datamem_wr_din0[15:0];
        end else begin
          wdata_d[15:0]  = datamem_wr_din0[15:0];
        end
      end
      3'b1??: wdata_d[{datamem_wr_strb[1:0], 3'b000} +: 8] = datamem_wr_din0[7:0];
      default: wdata_d = mem_q[datamem_wr_addr0];
    endcase
  end

  // Control FSM: busy is the registered state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= READY;
            ptr_q   <= '0;
          end else begin
            ptr_q   <= ptr_q + AW'(1);
          end
        end
        READY: begin
          if (clear_accept) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            err_q   <= 1'b0;
          end else if (wr_accept && strb_illegal) begin
            err_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Array has no reset; the CLEAR sequence zeroes it word by word.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_accept && !strb_illegal) begin
      mem_q[datamem_wr_addr0] <= wdata_d;
    end
  end

  assign busy             = (state_q == CLEAR);
  assign err_strb         = err_q;
  assign datamem_rd_dout0 = (state_q == CLEAR) ? '0 : mem_q[datamem_rd_addr0];

endmodule
